// File: rtl/iob_eth_mdio.sv
// MII management (MDIO/MDC) master: serialises clause-22 PHY register reads and
// writes, and optionally polls the PHY status register to track link state.
module iob_eth_mdio #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        cke_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_phy_addr_i,
    input  logic [4:0]  cmd_reg_addr_i,
    input  logic [15:0] cmd_wdata_i,
    output logic [15:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        scan_en_i,
    input  logic [4:0]  scan_phy_addr_i,
    output logic        busy_o,
    output logic        nvalid_o,
    output logic        linkfail_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_cmdReady;
    logic        w_busy;

    logic [DIV_W-1:0] r_div;
    logic [5:0]  r_bit;
    logic        r_mdc;
    logic        r_oe;
    logic [63:0] r_frame;
    logic        r_isRead;
    logic        r_isScan;
    logic        r_scanKeep;
    logic [15:0] r_rx;
    logic [15:0] r_rdata;
    logic        r_rdataValid;
    logic        r_nvalid;
    logic        r_linkfail;

    logic        w_accept;
    logic        w_scanStart;
    logic        w_start;
    logic        w_divEnd;
    logic        w_frameEnd;
    logic [63:0] w_newFrame;

    assign w_accept    = cmd_valid_i & (r_state == IDLE);
    assign w_scanStart = ~w_accept & scan_en_i & (r_state == IDLE);
    assign w_start     = w_accept | w_scanStart;
    assign w_divEnd    = (r_div == DIV_LAST);
    assign w_frameEnd  = (r_state == SHIFT) & w_divEnd & r_mdc & (r_bit == 6'd63);

    // Build the whole frame up front; read frames fill TA/DATA with ones since the pad is released there.
    always_comb begin
        w_newFrame = {32'hFFFF_FFFF, 2'b01, 2'b10, scan_phy_addr_i, 5'd1, 2'b11, 16'hFFFF};
        if (w_accept) begin
            if (cmd_write_i) begin
                w_newFrame = {32'hFFFF_FFFF, 2'b01, 2'b01, cmd_phy_addr_i, cmd_reg_addr_i,
                              2'b10, cmd_wdata_i};
            end else begin
                w_newFrame = {32'hFFFF_FFFF, 2'b01, 2'b10, cmd_phy_addr_i, cmd_reg_addr_i,
                              2'b11, 16'hFFFF};
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= IDLE;
        end else if (cke_i) begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_cmdReady  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmdReady = 1'b1;
                if (w_start) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (w_frameEnd) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // MDC toggles every CLK_DIV cycles; bits advance on the falling edge and reads sample on the rising edge.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_div        <= '0;
            r_bit        <= '0;
            r_mdc        <= 1'b0;
            r_oe         <= 1'b0;
            r_frame      <= '1;
            r_isRead     <= 1'b0;
            r_isScan     <= 1'b0;
            r_scanKeep   <= 1'b0;
            r_rx         <= '0;
            r_rdata      <= '0;
            r_rdataValid <= 1'b0;
            r_nvalid     <= 1'b1;
            r_linkfail   <= 1'b0;
        end else if (cke_i) begin
            r_rdataValid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    r_frame    <= w_newFrame;
                    r_oe       <= 1'b1;
                    r_mdc      <= 1'b0;
                    r_div      <= '0;
                    r_bit      <= '0;
                    r_isRead   <= w_scanStart | ~cmd_write_i;
                    r_isScan   <= w_scanStart;
                    r_scanKeep <= 1'b1;
                end
            end else begin
                if (!scan_en_i) begin
                    r_scanKeep <= 1'b0;
                end
                if (!w_divEnd) begin
                    r_div <= r_div + DIV_W'(1);
                end else begin
                    r_div <= '0;
                    if (!r_mdc) begin
                        r_mdc <= 1'b1;
                        if (r_isRead && (r_bit >= 6'd48)) begin
                            r_rx <= {r_rx[14:0], mdio_i};
                        end
                    end else begin
                        r_mdc <= 1'b0;
                        if (r_bit == 6'd63) begin
                            r_oe    <= 1'b0;
                            r_frame <= '1;
                            r_bit   <= '0;
                            if (r_isRead && r_isScan) begin
                                r_linkfail <= ~r_rx[2];
                                if (r_scanKeep && scan_en_i) begin
                                    r_nvalid <= 1'b0;
                                end
                            end else if (r_isRead) begin
                                r_rdata      <= r_rx;
                                r_rdataValid <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 6'd1;
                            r_frame <= {r_frame[62:0], 1'b1};
                            if (r_isRead && (r_bit == 6'd45)) begin
                                r_oe <= 1'b0;
                            end
                        end
                    end
                end
            end
            if (!scan_en_i) begin
                r_nvalid <= 1'b1;
            end
        end
    end

    assign cmd_ready_o   = w_cmdReady;
    assign busy_o        = w_busy;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rdataValid;
    assign nvalid_o      = r_nvalid;
    assign linkfail_o    = r_linkfail;
    assign mdc_o         = r_mdc;
    assign mdio_o        = r_frame[63];
    assign mdio_oe_o     = r_oe;

endmodule

// File: tb/tb_iob_eth_mdio.sv
// Directed testbench for iob_eth_mdio with CLK_DIV=2 and a behavioural PHY
// that captures the serial stream and answers reads from a response table.
module tb_iob_eth_mdio;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cke = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdWrite = 1'b0;
    logic [4:0]  cmdPhy = '0;
    logic [4:0]  cmdReg = '0;
    logic [15:0] cmdWdata = '0;
    logic [15:0] rdata;
    logic        rdataValid;
    logic        scanEn = 1'b0;
    logic [4:0]  scanPhy = 5'h09;
    logic        busy;
    logic        nvalid;
    logic        linkfail;
    logic        mdc;
    logic        mdio;
    logic        mdioOe;
    logic        mdioIn;

    int checks = 0;
    int errors = 0;

    logic [6:0]  kRise = '0;
    logic [6:0]  oeRise = '0;
    logic [63:0] frameBits = '1;
    logic [7:0]  frameIdx = '0;
    logic [15:0] respTable [4];
    logic [15:0] curResp;

    logic readyAt [340];
    logic oeAt    [340];
    logic validAt [340];
    logic mdcAt   [340];
    logic busyAt  [340];

    iob_eth_mdio #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .cke_i          (cke),
        .cmd_valid_i    (cmdValid),
        .cmd_ready_o    (cmdReady),
        .cmd_write_i    (cmdWrite),
        .cmd_phy_addr_i (cmdPhy),
        .cmd_reg_addr_i (cmdReg),
        .cmd_wdata_i    (cmdWdata),
        .rdata_o        (rdata),
        .rdata_valid_o  (rdataValid),
        .scan_en_i      (scanEn),
        .scan_phy_addr_i(scanPhy),
        .busy_o         (busy),
        .nvalid_o       (nvalid),
        .linkfail_o     (linkfail),
        .mdc_o          (mdc),
        .mdio_o         (mdio),
        .mdio_oe_o      (mdioOe),
        .mdio_i         (mdioIn)
    );

    always #5 clk = ~clk;

    // PHY model: restart bit tracking at each frame, capture what the master drives at MDC rise.
    always @(posedge busy) begin
        kRise     = '0;
        oeRise    = '0;
        frameBits = '1;
        frameIdx  = frameIdx + 8'd1;
    end

    always @(posedge mdc) begin
        frameBits = {frameBits[62:0], mdio};
        if (mdioOe) oeRise = oeRise + 7'd1;
        kRise = kRise + 7'd1;
    end

    assign curResp = respTable[frameIdx[1:0]];
    assign mdioIn  = (kRise >= 7'd48 && kRise <= 7'd63) ? curResp[4'(7'd63 - kRise)] : 1'b1;

    task automatic setResp(input logic [15:0] a, input logic [15:0] b);
        respTable[0] = a;
        for (int i = 1; i < 4; i++) respTable[i] = b;
    endtask

    task automatic runFrame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd, input int freezeAt, input int freezeLen);
        @(negedge clk);
        cmdWrite = wr; cmdPhy = phy; cmdReg = rg; cmdWdata = wd; cmdValid = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0; cmdWrite = ~wr; cmdPhy = ~phy; cmdReg = ~rg; cmdWdata = ~wd;
        for (int n = 1; n < 340; n++) begin
            readyAt[n] = cmdReady;
            oeAt[n]    = mdioOe;
            validAt[n] = rdataValid;
            mdcAt[n]   = mdc;
            busyAt[n]  = busy;
            if (freezeLen > 0 && n == freezeAt) cke = 1'b0;
            if (freezeLen > 0 && n == freezeAt + freezeLen) cke = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic waitBusy(input logic level, input string name);
        int cnt = 0;
        while (busy !== level && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (busy !== level) begin
            errors++;
            $display("[TB] FAIL %s: busy_o=%b, expected %b within 600 cycles", name, busy, level);
        end
    endtask

    task automatic test_reset();
        int badCycles = 0;
        repeat (3) @(negedge clk);
        checks++; if (cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b, expected 1", cmdReady); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (mdc !== 1'b0) begin errors++; $display("[TB] FAIL rst_mdc: got %b, expected 0", mdc); end
        checks++; if (mdio !== 1'b1) begin errors++; $display("[TB] FAIL rst_mdio: got %b, expected 1", mdio); end
        checks++; if (mdioOe !== 1'b0) begin errors++; $display("[TB] FAIL rst_oe: got %b, expected 0", mdioOe); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("[TB] FAIL rst_rdata: got %h, expected 0000", rdata); end
        checks++; if (rdataValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b, expected 0", rdataValid); end
        checks++; if (nvalid !== 1'b1) begin errors++; $display("[TB] FAIL rst_nvalid: got %b, expected 1", nvalid); end
        checks++; if (linkfail !== 1'b0) begin errors++; $display("[TB] FAIL rst_linkfail: got %b, expected 0", linkfail); end
        arst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mdc !== 1'b0 || mdioOe !== 1'b0 || nvalid !== 1'b1 || cmdReady !== 1'b1 ||
                linkfail !== 1'b0 || busy !== 1'b0) badCycles++;
        end
        checks++;
        if (badCycles != 0) begin
            errors++;
            $display("[TB] FAIL idle_hold: %0d bad idle cycles, expected 0", badCycles);
        end
    endtask

    task automatic test_host_write();
        runFrame(1'b1, 5'h01, 5'h00, 16'h1340, 0, 0);
        checks++; if (frameBits !== 64'hFFFF_FFFF_5082_1340) begin errors++; $display("[TB] FAIL wr_stream: got %h, expected ffffffff50821340", frameBits); end
        checks++; if (kRise !== 7'd64) begin errors++; $display("[TB] FAIL wr_mdc_rises: got %0d, expected 64", kRise); end
        checks++; if (oeRise !== 7'd64) begin errors++; $display("[TB] FAIL wr_oe_bits: got %0d, expected 64", oeRise); end
        checks++; if (readyAt[256] !== 1'b0) begin errors++; $display("[TB] FAIL wr_ready_256: got %b, expected 0", readyAt[256]); end
        checks++; if (readyAt[257] !== 1'b1) begin errors++; $display("[TB] FAIL wr_ready_257: got %b, expected 1", readyAt[257]); end
        checks++; if (busyAt[257] !== 1'b0 || mdcAt[257] !== 1'b0 || oeAt[257] !== 1'b0) begin errors++; $display("[TB] FAIL wr_end_idle: busy/mdc/oe=%b%b%b, expected 000", busyAt[257], mdcAt[257], oeAt[257]); end
        checks++; if (validAt[257] !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_valid: got %b, expected 0", validAt[257]); end
    endtask

    task automatic test_host_read();
        setResp(16'h0141, 16'h0141);
        runFrame(1'b0, 5'h03, 5'h02, 16'h0000, 0, 0);
        checks++; if (frameBits[63:18] !== {32'hFFFF_FFFF, 14'b01_10_00011_00010}) begin errors++; $display("[TB] FAIL rd_header: got %h, expected %h", frameBits[63:18], {32'hFFFF_FFFF, 14'b01_10_00011_00010}); end
        checks++; if (oeAt[184] !== 1'b1) begin errors++; $display("[TB] FAIL rd_oe_184: got %b, expected 1", oeAt[184]); end
        checks++; if (oeAt[185] !== 1'b0) begin errors++; $display("[TB] FAIL rd_oe_185: got %b, expected 0", oeAt[185]); end
        checks++; if (oeRise !== 7'd46) begin errors++; $display("[TB] FAIL rd_oe_bits: got %0d, expected 46", oeRise); end
        checks++; if (validAt[256] !== 1'b0 || validAt[257] !== 1'b1 || validAt[258] !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_pulse: 256..258=%b%b%b, expected 010", validAt[256], validAt[257], validAt[258]); end
        checks++; if (readyAt[257] !== 1'b1) begin errors++; $display("[TB] FAIL rd_ready_257: got %b, expected 1", readyAt[257]); end
        checks++; if (rdata !== 16'h0141) begin errors++; $display("[TB] FAIL rd_data: got %h, expected 0141", rdata); end
    endtask

    task automatic test_scan();
        setResp(16'h7809, 16'h782D);
        frameIdx = 8'hFF;
        @(negedge clk);
        scanEn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || nvalid !== 1'b1) begin errors++; $display("[TB] FAIL scan_start: busy/nvalid=%b%b, expected 11", busy, nvalid); end
        waitBusy(1'b0, "scan1_end");
        checks++; if (nvalid !== 1'b0) begin errors++; $display("[TB] FAIL scan1_nvalid: got %b, expected 0", nvalid); end
        checks++; if (linkfail !== 1'b1) begin errors++; $display("[TB] FAIL scan1_linkfail: got %b, expected 1", linkfail); end
        checks++; if (rdata !== 16'h0141) begin errors++; $display("[TB] FAIL scan1_rdata: got %h, expected 0141", rdata); end
        checks++; if (frameBits[63:18] !== {32'hFFFF_FFFF, 14'b01_10_01001_00001}) begin errors++; $display("[TB] FAIL scan1_header: got %h", frameBits[63:18]); end
        waitBusy(1'b1, "scan2_start");
        waitBusy(1'b0, "scan2_end");
        checks++; if (linkfail !== 1'b0) begin errors++; $display("[TB] FAIL scan2_linkfail: got %b, expected 0", linkfail); end
        checks++; if (rdata !== 16'h0141 || rdataValid !== 1'b0) begin errors++; $display("[TB] FAIL scan2_rdata: got %h/%b, expected 0141/0", rdata, rdataValid); end
        repeat (10) @(negedge clk);
        scanEn = 1'b0;
        @(negedge clk);
        checks++; if (nvalid !== 1'b1) begin errors++; $display("[TB] FAIL scan_off_nvalid: got %b, expected 1", nvalid); end
        waitBusy(1'b0, "scan3_end");
        checks++; if (nvalid !== 1'b1) begin errors++; $display("[TB] FAIL scan3_nvalid: got %b, expected 1", nvalid); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL scan_stopped: busy=%b, expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        setResp(16'hBEEF, 16'hBEEF);
        @(negedge clk);
        scanEn = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_scan_busy: got %b, expected 1", busy); end
        cmdWrite = 1'b0; cmdPhy = 5'h05; cmdReg = 5'h03; cmdValid = 1'b1;
        while (cmdReady !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cmdReady !== 1'b1 || busy !== 1'b0 || kRise !== 7'd64) begin errors++; $display("[TB] FAIL b2b_scan_end: ready/busy=%b%b rises=%0d, expected 10/64", cmdReady, busy, kRise); end
        checks++; if (frameBits[63:18] !== {32'hFFFF_FFFF, 14'b01_10_01001_00001}) begin errors++; $display("[TB] FAIL b2b_scan_header: got %h", frameBits[63:18]); end
        @(negedge clk);
        cmdValid = 1'b0; cmdPhy = 5'h1A; cmdReg = 5'h0C;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_host_start: busy=%b, expected 1", busy); end
        waitBusy(1'b0, "b2b_host_end");
        checks++; if (frameBits[63:18] !== {32'hFFFF_FFFF, 14'b01_10_00101_00011}) begin errors++; $display("[TB] FAIL b2b_host_header: got %h", frameBits[63:18]); end
        checks++; if (rdataValid !== 1'b1 || rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL b2b_host_data: got %h/%b, expected beef/1", rdata, rdataValid); end
        waitBusy(1'b1, "b2b_next_start");
        waitBusy(1'b0, "b2b_next_end");
        scanEn = 1'b0;
        checks++; if (frameBits[63:18] !== {32'hFFFF_FFFF, 14'b01_10_01001_00001}) begin errors++; $display("[TB] FAIL b2b_next_is_scan: got %h", frameBits[63:18]); end
        checks++; if (rdataValid !== 1'b0 || linkfail !== 1'b0) begin errors++; $display("[TB] FAIL b2b_next_result: valid/linkfail=%b%b, expected 00", rdataValid, linkfail); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clock_enable();
        int badCycles = 0;
        runFrame(1'b1, 5'h04, 5'h1B, 16'h0F0F, 12, 30);
        for (int n = 12; n <= 42; n++) if (mdcAt[n] !== 1'b1) badCycles++;
        checks++; if (badCycles != 0) begin errors++; $display("[TB] FAIL cke_mdc_hold: %0d cycles not high, expected 0", badCycles); end
        checks++; if (readyAt[286] !== 1'b0 || readyAt[287] !== 1'b1) begin errors++; $display("[TB] FAIL cke_stretch: ready 286/287=%b%b, expected 01", readyAt[286], readyAt[287]); end
        checks++; if (frameBits !== 64'hFFFF_FFFF_526E_0F0F) begin errors++; $display("[TB] FAIL cke_stream: got %h, expected ffffffff526e0f0f", frameBits); end
    endtask

    task automatic test_reset_mid_frame();
        int pulses = 0;
        setResp(16'h1234, 16'h1234);
        @(negedge clk);
        cmdWrite = 1'b0; cmdPhy = 5'h02; cmdReg = 5'h04; cmdValid = 1'b1;
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (160) @(negedge clk);
        checks++; if (busy !== 1'b1 || kRise !== 7'd40) begin errors++; $display("[TB] FAIL mid_position: busy=%b rises=%0d, expected 1/40", busy, kRise); end
        arst = 1'b1;
        #1;
        checks++; if (mdc !== 1'b0 || mdioOe !== 1'b0 || busy !== 1'b0 || cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_now: mdc/oe/busy/ready=%b%b%b%b, expected 0001", mdc, mdioOe, busy, cmdReady); end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdataValid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || rdata !== 16'h0000) begin errors++; $display("[TB] FAIL mid_no_valid: pulses=%0d rdata=%h, expected 0/0000", pulses, rdata); end
        runFrame(1'b1, 5'h1F, 5'h10, 16'hA5C3, 0, 0);
        checks++; if (frameBits !== 64'hFFFF_FFFF_5FC2_A5C3) begin errors++; $display("[TB] FAIL mid_after_write: got %h, expected ffffffff5fc2a5c3", frameBits); end
        checks++; if (readyAt[256] !== 1'b0 || readyAt[257] !== 1'b1) begin errors++; $display("[TB] FAIL mid_after_ready: 256/257=%b%b, expected 01", readyAt[256], readyAt[257]); end
    endtask

    initial begin
        setResp(16'hFFFF, 16'hFFFF);
        test_reset();
        test_host_write();
        test_host_read();
        test_scan();
        test_back_to_back();
        test_clock_enable();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
